// File: rtl/risc_decode_exec.sv
// Decode/execute stage of the single-issue RISC core: register file, ALU,
// branch/jump resolution and writeback, producing the registered next PC.
module risc_decode_exec #(
  parameter logic [5:0] NOP_OP = 6'b111111,
  parameter int         NREGS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrn,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] r_regs [NREGS];
  logic [31:0] r_pc_next;

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sh;
  logic [5:0]  w_fn;
  logic [15:0] w_imm;
  logic [25:0] w_tgt;

  logic [31:0]        w_rs_val;
  logic [31:0]        w_rt_val;
  logic signed [31:0] w_rs_s;
  logic signed [31:0] w_rt_s;
  logic signed [31:0] w_sext;
  logic [31:0]        w_zext;
  logic [31:0]        w_pc_seq;
  logic [31:0]        w_br_tgt;

  logic        w_wr_en;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic [31:0] w_pc_nxt;

  assign w_op  = instrn[31:26];
  assign w_rs  = instrn[25:21];
  assign w_rt  = instrn[20:16];
  assign w_rd  = instrn[15:11];
  assign w_sh  = instrn[10:6];
  assign w_fn  = instrn[5:0];
  assign w_imm = instrn[15:0];
  assign w_tgt = instrn[25:0];

  // Operands come from the pre-edge register state; r0 is hardwired to zero.
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];
  assign w_rs_s   = w_rs_val;
  assign w_rt_s   = w_rt_val;
  assign w_sext   = {{16{w_imm[15]}}, w_imm};
  assign w_zext   = {16'h0000, w_imm};
  assign w_pc_seq = pc_in + 32'd1;
  assign w_br_tgt = w_pc_seq + w_sext;

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = w_rd;
    w_wr_data = 32'd0;
    w_pc_nxt  = w_pc_seq;
    case (w_op)
      6'b000000: begin
        w_wr_en = 1'b1;
        case (w_fn)
          6'b000000: w_wr_data = w_rs_val + w_rt_val;
          6'b000001: w_wr_data = w_rs_val - w_rt_val;
          6'b000010: w_wr_data = w_rs_val & w_rt_val;
          6'b000011: w_wr_data = w_rs_val | w_rt_val;
          6'b000100: w_wr_data = w_rs_val ^ w_rt_val;
          6'b000101: w_wr_data = w_rt_val << w_sh;
          6'b000110: w_wr_data = w_rt_val >> w_sh;
          6'b000111: w_wr_data = (w_rs_s < w_rt_s) ? 32'd1 : 32'd0;
          default:   w_wr_en   = 1'b0;
        endcase
      end
      6'b000001: begin
        w_wr_en   = 1'b1;
        w_wr_addr = w_rt;
        w_wr_data = w_rs_val + w_sext;
      end
      6'b000010: begin
        w_wr_en   = 1'b1;
        w_wr_addr = w_rt;
        w_wr_data = w_rs_val & w_zext;
      end
      6'b000011: begin
        w_wr_en   = 1'b1;
        w_wr_addr = w_rt;
        w_wr_data = w_rs_val | w_zext;
      end
      6'b000100: begin
        w_wr_en   = 1'b1;
        w_wr_addr = w_rt;
        w_wr_data = {w_imm, 16'h0000};
      end
      6'b000101: if (w_rs_val == w_rt_val) w_pc_nxt = w_br_tgt;
      6'b000110: if (w_rs_val != w_rt_val) w_pc_nxt = w_br_tgt;
      6'b000111: w_pc_nxt = {pc_in[31:26], w_tgt};
      NOP_OP:    w_wr_en = 1'b0;
      default:   w_wr_en = 1'b0;
    endcase
  end

  // Writeback / next-PC boundary; reset wins over any pending write or branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc_next <= 32'd0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 32'd0;
    end else begin
      r_pc_next <= w_pc_nxt;
      if (w_wr_en && (w_wr_addr != 5'd0)) r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  assign pc_next  = r_pc_next;
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : r_regs[dbg_addr];

endmodule

// File: tb/tb_risc_decode_exec.sv
// Directed-vector bench for risc_decode_exec: hand-computed register and PC
// results for ALU, immediate, branch, jump, NOP and reset cases.
module tb_risc_decode_exec;

  logic        clk;
  logic        rst;
  logic [31:0] instrn;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_vec;
  int n_err;

  localparam logic [31:0] NOP = 32'hFC000000;

  risc_decode_exec dut (
    .clk      (clk),
    .rst      (rst),
    .instrn   (instrn),
    .pc_in    (pc_in),
    .pc_next  (pc_next),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One instruction per edge; afterwards a NOP is parked on the bus so that
  // the settle delays used for register reads never re-execute the vector.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc);
    instrn = ins;
    pc_in  = pc;
    @(posedge clk);
    #1;
    instrn = NOP;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check_eq(tag, dbg_data, exp);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b0;
    dbg_addr = 5'd0;
    instrn   = NOP;
    pc_in    = 32'd0;
    @(negedge clk);

    // Reset edge with a live ADDI on the bus: must be ignored.
    step(enc_i(6'b000001, 5'd0, 5'd1, 16'd5), 32'd0);
    check_eq("rst_pc", pc_next, 32'd0);
    check_reg("rst_r1", 5'd1, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    step(enc_i(6'b000001, 5'd0, 5'd1, 16'd5), 32'd0);
    check_eq("addi_pc", pc_next, 32'd1);
    check_reg("addi_r1", 5'd1, 32'd5);
    step(enc_i(6'b000001, 5'd0, 5'd2, 16'hFFFD), 32'd1);
    check_reg("addi_neg_r2", 5'd2, 32'hFFFFFFFD);
    step(enc_r(6'b000000, 5'd3, 5'd1, 5'd2, 5'd0), 32'd2);
    check_eq("add_pc", pc_next, 32'd3);
    check_reg("add_r3", 5'd3, 32'd2);

    step(enc_r(6'b000001, 5'd4, 5'd2, 5'd1, 5'd0), 32'd3);
    check_reg("sub_r4", 5'd4, 32'hFFFFFFF8);
    step(enc_r(6'b000111, 5'd5, 5'd2, 5'd1, 5'd0), 32'd4);
    check_reg("slt_r5", 5'd5, 32'd1);
    step(enc_r(6'b000101, 5'd6, 5'd0, 5'd1, 5'd4), 32'd5);
    check_reg("sll_r6", 5'd6, 32'd80);
    step(enc_r(6'b000110, 5'd8, 5'd0, 5'd2, 5'd28), 32'd6);
    check_reg("srl_r8", 5'd8, 32'h0000000F);
    step(enc_r(6'b000010, 5'd9, 5'd1, 5'd2, 5'd0), 32'd7);
    check_reg("and_r9", 5'd9, 32'd5);
    step(enc_r(6'b000011, 5'd10, 5'd1, 5'd2, 5'd0), 32'd8);
    check_reg("or_r10", 5'd10, 32'hFFFFFFFD);
    step(enc_r(6'b000100, 5'd11, 5'd1, 5'd2, 5'd0), 32'd9);
    check_reg("xor_r11", 5'd11, 32'hFFFFFFF8);
    step(enc_r(6'b000111, 5'd12, 5'd1, 5'd2, 5'd0), 32'd10);
    check_reg("slt_false_r12", 5'd12, 32'd0);
    step(enc_i(6'b000010, 5'd2, 5'd13, 16'h00F0), 32'd11);
    check_reg("andi_r13", 5'd13, 32'h000000F0);
    step(enc_r(6'b001000, 5'd1, 5'd2, 5'd2, 5'd0), 32'd12);
    check_reg("badfn_r1", 5'd1, 32'd5);

    step(enc_i(6'b000101, 5'd1, 5'd1, 16'hFFFE), 32'd10);
    check_eq("beq_taken", pc_next, 32'd9);
    step(enc_i(6'b000110, 5'd1, 5'd1, 16'hFFFE), 32'd10);
    check_eq("bne_not", pc_next, 32'd11);
    step(enc_i(6'b000110, 5'd1, 5'd2, 16'd5), 32'd20);
    check_eq("bne_taken", pc_next, 32'd26);
    step(enc_i(6'b000101, 5'd1, 5'd2, 16'd5), 32'd20);
    check_eq("beq_not", pc_next, 32'd21);

    step({6'b000111, 26'h0000100}, 32'd7);
    check_eq("j_pc", pc_next, 32'h00000100);
    step({6'b000111, 26'h0000003}, 32'hFC000005);
    check_eq("j_hi_pc", pc_next, 32'hFC000003);
    step(NOP, 32'd8);
    check_eq("nop_pc", pc_next, 32'd9);
    check_reg("nop_r1", 5'd1, 32'd5);
    step(NOP, 32'hFFFFFFFF);
    check_eq("pc_wrap", pc_next, 32'd0);

    step(enc_i(6'b000001, 5'd0, 5'd0, 16'd7), 32'd30);
    check_reg("r0_zero", 5'd0, 32'd0);
    step(enc_i(6'b000100, 5'd0, 5'd7, 16'hABCD), 32'd31);
    check_reg("lui_r7", 5'd7, 32'hABCD0000);
    step(enc_i(6'b000011, 5'd7, 5'd7, 16'h1234), 32'd32);
    check_reg("ori_r7", 5'd7, 32'hABCD1234);

    // Mid-program reset beats a pending write and a taken jump.
    rst = 1'b0;
    step({6'b000111, 26'h0000200}, 32'd50);
    check_eq("rst_mid_pc", pc_next, 32'd0);
    check_reg("rst_mid_r1", 5'd1, 32'd0);
    check_reg("rst_mid_r7", 5'd7, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
